// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: turns a packet request plus a 32-bit payload stream
// into one byte-counted beat stream: header (DI, WC LSB, WC MSB, ECC), then
// for long packets the payload beats and a 2-byte CRC footer.
module dsi_packet_assembler #(
    parameter bit CRC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [7:0]  pkt_data_id,
    input  logic [15:0] pkt_word_count,
    input  logic        pkt_long,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [31:0] pl_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_nbytes,
    output logic        out_last
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } state_t;

    // Parity masks over the 24 header bits {WC, DI}; bit n of mask p means
    // header bit n contributes to ECC parity bit p. ECC bits 7:6 are zero.
    localparam logic [5:0][23:0] ECC_MASK = {
        24'hEFFC00,   // P5
        24'hDF03F0,   // P4
        24'hB8E38E,   // P3
        24'h749A6D,   // P2
        24'hF2555B,   // P1
        24'hF12CB7    // P0
    };

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_di;
    logic [15:0]   r_wc;
    logic          r_long;
    logic [7:0]    r_ecc;
    logic [15:0]   r_remaining;
    logic [15:0]   r_crc;

    logic [23:0]   w_ecc_in;
    logic [7:0]    w_ecc;
    logic          w_accept;
    logic          w_pl_xfer;
    logic [1:0]    w_nbytes;
    logic [15:0]   w_crc_stage [0:4];
    logic [15:0]   w_crc_upd;
    logic [15:0]   w_crc_out;

    // One byte of the reflected CRC-16 (x^16+x^12+x^5+1), bit 0 first on wire.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i])
                c = (c >> 1) ^ 16'h8408;
            else
                c = c >> 1;
        end
        return c;
    endfunction

    assign w_accept  = (r_state == ST_IDLE) && pkt_valid;
    assign w_pl_xfer = (r_state == ST_PAYLOAD) && pl_valid && out_ready;

    // The final payload word may carry fewer than four live bytes.
    assign w_nbytes  = (r_remaining >= 16'd4) ? 2'd3 : (r_remaining[1:0] - 2'd1);

    // ECC is computed from the request inputs and captured with the fields,
    // so the header beat is driven purely from registers.
    assign w_ecc_in  = {pkt_word_count, pkt_data_id};
    assign w_ecc[7:6] = 2'b00;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_ecc
            assign w_ecc[gi] = ^(w_ecc_in & ECC_MASK[gi]);
        end
    endgenerate

    // Chain of per-byte CRC updates; the tap taken depends on live byte count.
    assign w_crc_stage[0] = r_crc;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_crc
            assign w_crc_stage[gi + 1] = crc16_byte(w_crc_stage[gi], pl_data[8*gi +: 8]);
        end
    endgenerate

    // Select the CRC after exactly out_nbytes+1 bytes of this word.
    always_comb begin
        w_crc_upd = w_crc_stage[4];
        case (w_nbytes)
            2'd0:    w_crc_upd = w_crc_stage[1];
            2'd1:    w_crc_upd = w_crc_stage[2];
            2'd2:    w_crc_upd = w_crc_stage[3];
            default: w_crc_upd = w_crc_stage[4];
        endcase
    end

    assign w_crc_out = CRC_EN ? r_crc : 16'h0000;

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state decode driven by the request, payload and output handshakes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (pkt_valid)
                    w_state_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (out_ready) begin
                    if (!r_long)
                        w_state_next = ST_IDLE;
                    else if (r_wc == 16'd0)
                        w_state_next = ST_CRC;
                    else
                        w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_pl_xfer && (r_remaining <= 16'd4))
                    w_state_next = ST_CRC;
            end
            ST_CRC: begin
                if (out_ready)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode per state; payload beats pass straight through.
    always_comb begin
        pkt_ready  = 1'b0;
        pl_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 32'h0;
        out_nbytes = 2'd0;
        out_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                pkt_ready = 1'b1;
            end
            ST_HEADER: begin
                out_valid  = 1'b1;
                out_data   = {r_ecc, r_wc[15:8], r_wc[7:0], r_di};
                out_nbytes = 2'd3;
                out_last   = !r_long;
            end
            ST_PAYLOAD: begin
                out_valid  = pl_valid;
                pl_ready   = out_ready;
                out_data   = pl_data;
                out_nbytes = w_nbytes;
            end
            ST_CRC: begin
                out_valid  = 1'b1;
                out_data   = {16'h0000, w_crc_out};
                out_nbytes = 2'd1;
                out_last   = 1'b1;
            end
            default: ;
        endcase
    end

    // Request fields are captured once at acceptance and ignored afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_di   <= 8'h00;
            r_wc   <= 16'h0000;
            r_long <= 1'b0;
            r_ecc  <= 8'h00;
        end else if (w_accept) begin
            r_di   <= pkt_data_id;
            r_wc   <= pkt_word_count;
            r_long <= pkt_long;
            r_ecc  <= w_ecc;
        end
    end

    // Remaining payload bytes: loaded while the header is up, drained per word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_remaining <= 16'h0000;
        else if (r_state == ST_HEADER)
            r_remaining <= r_wc;
        else if (w_pl_xfer)
            r_remaining <= r_remaining - ({14'd0, w_nbytes} + 16'd1);
    end

    // CRC accumulator: reseeded on each accepted request, updated per word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_crc <= 16'hFFFF;
        else if (w_accept)
            r_crc <= 16'hFFFF;
        else if (w_pl_xfer)
            r_crc <= w_crc_upd;
    end

endmodule
